reorder_buffer: RTL

- Circular in-order reorder buffer. It is the receiving end of the decoder's ROB dispatch interface.
- Allocates one entry per dispatched instruction at the tail and collects results from the RS and LSB common data buses.
- Commits ready entries in order from the head: register writes, store release, halt.
- Detects taken-branch mispredicts (the fetch default is not-taken) and issues a global flush with the redirect PC.

---
 rtl/reorder_buffer_if.sv | 28 ++
 rtl/reorder_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Decoder-to-ROB dispatch channel: the decoder presents one entry per cycle and
// the ROB answers with its stall flag and the id the next entry will receive.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH_BIT = 3,
  parameter int ROB_TYPE_BIT  = 2
);
  logic                     rob_valid;
  logic [ROB_TYPE_BIT-1:0]  rob_type;
  logic [4:0]               rob_reg_id;
  logic [31:0]              rob_value;
  logic [31:0]              rob_inst_addr;
  logic [31:0]              rob_jump_addr;
  logic                     rob_ready;
  logic                     rob_full;
  logic [ROB_WIDTH_BIT-1:0] rob_free_id;

  modport master (
    output rob_valid, rob_type, rob_reg_id, rob_value,
           rob_inst_addr, rob_jump_addr, rob_ready,
    input  rob_full, rob_free_id
  );

  modport slave (
    input  rob_valid, rob_type, rob_reg_id, rob_value,
           rob_inst_addr, rob_jump_addr, rob_ready,
    output rob_full, rob_free_id
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at the tail, gathers CDB results,
// retires from the head and flushes the machine on a taken branch.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3,
  parameter int ROB_TYPE_BIT  = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  reorder_buffer_if.slave          disp,
  input  logic                     rs_cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] rs_cdb_rob_id,
  input  logic [31:0]              rs_cdb_value,
  input  logic                     lsb_cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_cdb_rob_id,
  input  logic [31:0]              lsb_cdb_value,
  output logic                     rf_rename_valid,
  output logic [4:0]               rf_rename_reg,
  output logic [ROB_WIDTH_BIT-1:0] rf_rename_rob,
  output logic                     rf_commit_valid,
  output logic [4:0]               rf_commit_reg,
  output logic [ROB_WIDTH_BIT-1:0] rf_commit_rob,
  output logic [31:0]              rf_commit_value,
  output logic                     lsb_store_commit,
  output logic [ROB_WIDTH_BIT-1:0] lsb_store_rob,
  output logic                     flush,
  output logic [31:0]              if_set_addr,
  output logic                     halt
);
  localparam int unsigned SIZE = 2 ** ROB_WIDTH_BIT;
  localparam logic [ROB_TYPE_BIT-1:0] TYPE_RG = ROB_TYPE_BIT'(0);
  localparam logic [ROB_TYPE_BIT-1:0] TYPE_ST = ROB_TYPE_BIT'(1);
  localparam logic [ROB_TYPE_BIT-1:0] TYPE_BR = ROB_TYPE_BIT'(2);
  localparam logic [ROB_TYPE_BIT-1:0] TYPE_EX = ROB_TYPE_BIT'(3);

  typedef logic [ROB_WIDTH_BIT-1:0] id_t;
  typedef logic [ROB_WIDTH_BIT:0]   cnt_t;

  // The PC is not kept: only the jump target is needed at retirement.
  logic                    busy_q  [SIZE], busy_d  [SIZE];
  logic                    ready_q [SIZE], ready_d [SIZE];
  logic [ROB_TYPE_BIT-1:0] type_q  [SIZE], type_d  [SIZE];
  logic [4:0]              reg_q   [SIZE], reg_d   [SIZE];
  logic [31:0]             value_q [SIZE], value_d [SIZE];
  logic [31:0]             jump_q  [SIZE], jump_d  [SIZE];

  id_t         head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic        halt_q, halt_d, flush_q, flush_d, drop_q, drop_d;
  logic [31:0] if_set_addr_q, if_set_addr_d;
  logic        rename_valid_q, rename_valid_d;
  logic [4:0]  rename_reg_q, rename_reg_d;
  id_t         rename_rob_q, rename_rob_d;
  logic        commit_valid_q, commit_valid_d;
  logic [4:0]  commit_reg_q, commit_reg_d;
  id_t         commit_rob_q, commit_rob_d;
  logic [31:0] commit_value_q, commit_value_d;
  logic        store_commit_q, store_commit_d;
  id_t         store_rob_q, store_rob_d;

  logic commit_en, alloc_en, taken;

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    type_d  = type_q;
    reg_d   = reg_q;
    value_d = value_q;
    jump_d  = jump_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halt_d  = halt_q;
    flush_d = flush_q;
    drop_d  = drop_q;
    if_set_addr_d  = if_set_addr_q;
    rename_valid_d = rename_valid_q;
    rename_reg_d   = rename_reg_q;
    rename_rob_d   = rename_rob_q;
    commit_valid_d = commit_valid_q;
    commit_reg_d   = commit_reg_q;
    commit_rob_d   = commit_rob_q;
    commit_value_d = commit_value_q;
    store_commit_d = store_commit_q;
    store_rob_d    = store_rob_q;
    commit_en = 1'b0;
    alloc_en  = 1'b0;
    taken     = 1'b0;

    if (rdy_in) begin
      flush_d        = 1'b0;
      if_set_addr_d  = '0;
      rename_valid_d = 1'b0;
      rename_reg_d   = '0;
      rename_rob_d   = '0;
      commit_valid_d = 1'b0;
      commit_reg_d   = '0;
      commit_rob_d   = '0;
      commit_value_d = '0;
      store_commit_d = 1'b0;
      store_rob_d    = '0;
      drop_d         = flush_q;

      commit_en = !halt_q && busy_q[head_q] && ready_q[head_q];
      taken     = commit_en && (type_q[head_q] == TYPE_BR) && value_q[head_q][0];
      // The decoder clears itself on flush, so dispatches in the flush cycle and the one after are stale.
      alloc_en  = disp.rob_valid && !flush_q && !drop_q && !taken;

      // LSB is applied second so it wins when both buses hit the same id.
      if (rs_cdb_valid && busy_q[rs_cdb_rob_id]) begin
        value_d[rs_cdb_rob_id] = rs_cdb_value;
        ready_d[rs_cdb_rob_id] = 1'b1;
      end
      if (lsb_cdb_valid && busy_q[lsb_cdb_rob_id]) begin
        value_d[lsb_cdb_rob_id] = lsb_cdb_value;
        ready_d[lsb_cdb_rob_id] = 1'b1;
      end

      if (commit_en) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
        case (type_q[head_q])
          TYPE_RG: if (reg_q[head_q] != '0) begin
            commit_valid_d = 1'b1;
            commit_reg_d   = reg_q[head_q];
            commit_rob_d   = head_q;
            commit_value_d = value_q[head_q];
          end
          TYPE_ST: begin
            store_commit_d = 1'b1;
            store_rob_d    = head_q;
          end
          TYPE_BR: if (taken) begin
            flush_d       = 1'b1;
            if_set_addr_d = jump_q[head_q];
          end
          TYPE_EX: halt_d = 1'b1;
          default: ;
        endcase
      end

      if (alloc_en) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = disp.rob_ready;
        type_d[tail_q]  = disp.rob_type;
        reg_d[tail_q]   = disp.rob_reg_id;
        value_d[tail_q] = disp.rob_value;
        jump_d[tail_q]  = disp.rob_jump_addr;
        tail_d          = tail_q + 1'b1;
        if (disp.rob_type == TYPE_RG && disp.rob_reg_id != '0) begin
          rename_valid_d = 1'b1;
          rename_reg_d   = disp.rob_reg_id;
          rename_rob_d   = tail_q;
        end
      end

      count_d = count_q + cnt_t'(alloc_en) - cnt_t'(commit_en);

      if (taken) begin
        for (int unsigned i = 0; i < SIZE; i++) busy_d[i] = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q  <= '{default: 1'b0};
      ready_q <= '{default: 1'b0};
      type_q  <= '{default: '0};
      reg_q   <= '{default: '0};
      value_q <= '{default: '0};
      jump_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
      flush_q <= 1'b0;
      drop_q  <= 1'b0;
      if_set_addr_q  <= '0;
      rename_valid_q <= 1'b0;
      rename_reg_q   <= '0;
      rename_rob_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_rob_q   <= '0;
      commit_value_q <= '0;
      store_commit_q <= 1'b0;
      store_rob_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      type_q  <= type_d;
      reg_q   <= reg_d;
      value_q <= value_d;
      jump_q  <= jump_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
      flush_q <= flush_d;
      drop_q  <= drop_d;
      if_set_addr_q  <= if_set_addr_d;
      rename_valid_q <= rename_valid_d;
      rename_reg_q   <= rename_reg_d;
      rename_rob_q   <= rename_rob_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_rob_q   <= commit_rob_d;
      commit_value_q <= commit_value_d;
      store_commit_q <= store_commit_d;
      store_rob_q    <= store_rob_d;
    end
  end

  // One slot stays reserved for the dispatch already registered inside the decoder.
  assign disp.rob_full    = (count_q >= cnt_t'(SIZE - 1));
  assign disp.rob_free_id = tail_q;

  assign rf_rename_valid  = rename_valid_q;
  assign rf_rename_reg    = rename_reg_q;
  assign rf_rename_rob    = rename_rob_q;
  assign rf_commit_valid  = commit_valid_q;
  assign rf_commit_reg    = commit_reg_q;
  assign rf_commit_rob    = commit_rob_q;
  assign rf_commit_value  = commit_value_q;
  assign lsb_store_commit = store_commit_q;
  assign lsb_store_rob    = store_rob_q;
  assign flush            = flush_q;
  assign if_set_addr      = if_set_addr_q;
  assign halt             = halt_q;
endmodule
